// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and constants for the IF/MEM memory-port
//                arbiter: FSM state encoding, starvation counter sizing and
//                a saturating-increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_DM_BUSY = 2'd2
  } arb_state_t;

  // Default bus geometry
  localparam int c_ADDR_W_DEF     = 32;
  localparam int c_DATA_W_DEF     = 32;

  // Default number of consecutive data grants tolerated while a fetch waits
  localparam int c_STARVE_MAX_DEF = 4;

  // Starvation counter width; covers the legal STARVE_MAX range of 1..15
  localparam int c_STARVE_W       = 4;

  // Byte-enable pattern used for instruction fetches (always a full word)
  localparam logic [3:0] c_BE_FULL = 4'hF;

  // Increment that holds at the limit instead of wrapping
  function automatic logic [c_STARVE_W-1:0] f_sat_inc(
    input logic [c_STARVE_W-1:0] cur,
    input logic [c_STARVE_W-1:0] lim
  );
    if (cur >= lim) begin
      return lim;
    end
    return cur + 1'b1;
  endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch port, data port and unified memory bus
//                signals around the memory-port arbiter. The slave modport is
//                the arbiter's view; the master modport is the view of the
//                surrounding pipeline and memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction-fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_valid_o;
  logic              if_stall_o;

  // Data-memory port
  logic              dm_req_i;
  logic              dm_we_i;
  logic [3:0]        dm_be_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_valid_o;
  logic              dm_stall_o;

  // Unified memory bus
  logic              bus_req_o;
  logic              bus_we_o;
  logic [3:0]        bus_be_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ready_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_rdata_o, if_valid_o, if_stall_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_valid_o, dm_stall_o,
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    input  bus_rdata_i, bus_ready_i
  );

  // Pipeline / memory side
  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_rdata_o, if_valid_o, if_stall_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_valid_o, dm_stall_o,
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    output bus_rdata_i, bus_ready_i
  );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory bus between the instruction
//                fetch requester and the MEM-stage load/store requester.
//                One transaction at a time; the data port has priority, but
//                a waiting fetch wins after STARVE_MAX consecutive data
//                grants. Produces per-port stall signals for the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = c_ADDR_W_DEF,
  parameter int DATA_W     = c_DATA_W_DEF,
  parameter int STARVE_MAX = c_STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   io
);

  localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t              r_state;
  logic [c_STARVE_W-1:0]   r_starve;
  logic                    r_drop;

  logic                    r_bus_req;
  logic                    r_bus_we;
  logic [3:0]              r_bus_be;
  logic [ADDR_W-1:0]       r_bus_addr;
  logic [DATA_W-1:0]       r_bus_wdata;

  logic [DATA_W-1:0]       r_if_rdata;
  logic                    r_if_valid;
  logic [DATA_W-1:0]       r_dm_rdata;
  logic                    r_dm_valid;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic w_if_valid;
  logic w_if_elig;
  logic w_dm_elig;
  logic w_pick_if;
  logic w_pick_dm;
  logic w_done;
  logic w_if_discard;

  // A redirect in the completion cycle kills the pulse that would announce
  // the stale instruction.
  assign w_if_valid   = r_if_valid & ~io.if_flush_i;

  // A port is ineligible in its own completion cycle so a request that is
  // still held high is not granted twice.
  assign w_if_elig    = io.if_req_i & ~w_if_valid & ~io.if_flush_i;
  assign w_dm_elig    = io.dm_req_i & ~r_dm_valid;

  // Data wins ties unless the fetch has already waited out STARVE_MAX grants
  assign w_pick_if    = w_if_elig & (~w_dm_elig | (r_starve == c_STARVE_LIM));
  assign w_pick_dm    = w_dm_elig & ~w_pick_if;

  // bus_req_o is only high in a busy state, so ready outside one is ignored
  assign w_done       = r_bus_req & io.bus_ready_i;

  // Fetch result is thrown away if a flush arrived during or at completion
  assign w_if_discard = r_drop | io.if_flush_i;

  // --------------------------------------------------------------------------
  // Arbiter FSM, bus command registers, result capture and starvation count
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_starve    <= '0;
      r_drop      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_rdata  <= '0;
      r_dm_valid  <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;

      case (r_state)
        ARB_IDLE: begin
          if (w_pick_if) begin
            r_state     <= ARB_IF_BUSY;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_be    <= c_BE_FULL;
            r_bus_addr  <= io.if_addr_i;
            r_bus_wdata <= '0;
            r_starve    <= '0;
          end else if (w_pick_dm) begin
            r_state     <= ARB_DM_BUSY;
            r_bus_req   <= 1'b1;
            r_bus_we    <= io.dm_we_i;
            r_bus_be    <= io.dm_be_i;
            r_bus_addr  <= io.dm_addr_i;
            r_bus_wdata <= io.dm_wdata_i;
            // Only data grants that keep a fetch waiting count as starvation
            if (io.if_req_i) begin
              r_starve <= f_sat_inc(r_starve, c_STARVE_LIM);
            end else begin
              r_starve <= '0;
            end
          end else if (!io.if_req_i) begin
            r_starve <= '0;
          end
        end

        ARB_IF_BUSY: begin
          if (w_done) begin
            r_state   <= ARB_IDLE;
            r_bus_req <= 1'b0;
            r_drop    <= 1'b0;
            if (!w_if_discard) begin
              r_if_rdata <= io.bus_rdata_i;
              r_if_valid <= 1'b1;
            end
          end else if (io.if_flush_i) begin
            // The bus cannot abort, so remember to swallow the result
            r_drop <= 1'b1;
          end
        end

        ARB_DM_BUSY: begin
          if (w_done) begin
            r_state    <= ARB_IDLE;
            r_bus_req  <= 1'b0;
            r_dm_valid <= 1'b1;
            // Stores keep the last load result visible
            if (!r_bus_we) begin
              r_dm_rdata <= io.bus_rdata_i;
            end
          end
        end

        default: begin
          r_state   <= ARB_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign io.bus_req_o   = r_bus_req;
  assign io.bus_we_o    = r_bus_we;
  assign io.bus_be_o    = r_bus_be;
  assign io.bus_addr_o  = r_bus_addr;
  assign io.bus_wdata_o = r_bus_wdata;

  assign io.if_rdata_o  = r_if_rdata;
  assign io.if_valid_o  = w_if_valid;
  assign io.if_stall_o  = io.if_req_i & ~w_if_valid;

  assign io.dm_rdata_o  = r_dm_rdata;
  assign io.dm_valid_o  = r_dm_valid;
  assign io.dm_stall_o  = io.dm_req_i & ~r_dm_valid;

  // A data request must stay up until its transaction completes
  a_dm_req_held : assert property (
    @(posedge clk) disable iff (rst) (r_state == ARB_DM_BUSY) |-> io.dm_req_i
  );

endmodule : mem_port_arbiter
`default_nettype wire
